nn_bram_host_sequencer: RTL and testbench

- Host-side initiator for forward_nn_classification_bram.
- Accepts a 64-bit load stream and writes feature words into the xij BRAM port A, then weight/bias words into the wb BRAM port A.
- Pulses start, waits for done, reads the result logits from xout port B and returns them on a 16-bit output stream with argmax class.
- Replaces the hand-driven load/start/readback sequence, allowing back-to-back inferences from a DMA/UART front end.

---
 rtl/nn_host_pkg.sv | 30 +++
 rtl/nn_argmax_tracker.sv | 44 ++++
 rtl/nn_bram_host_sequencer.sv | 215 +++++++++++++++++++++
 tb/tb_nn_bram_host_sequencer.sv | 369 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nn_host_pkg.sv
// Shared types and constants for the NN BRAM host sequencer.
// Contents: sequencer state encoding, default inference geometry,
// full-word byte-enable constant and a load-state helper.
package nn_host_pkg;

  typedef enum logic [3:0] {
    IDLE,
    LOAD_X,
    LOAD_WB,
    WAIT_RDY,
    START,
    WAIT_DONE,
    READ,
    HOLD,
    DONE
  } state_t;

  localparam int unsigned DEF_N_X   = 9;
  localparam int unsigned DEF_N_WB  = 10;
  localparam int unsigned DEF_N_OUT = 4;
  localparam int unsigned WE_W      = 8;

  localparam logic [WE_W-1:0] WE_ALL = 8'hFF;

  // States in which the load stream is accepted.
  function automatic logic is_load(input state_t s);
    return (s == IDLE) || (s == LOAD_X) || (s == LOAD_WB);
  endfunction

endpackage

// File: rtl/nn_argmax_tracker.sv
// Streaming signed maximum with index.
// Ports:
//   clk, rst  - clock, asynchronous active-high reset
//   clear     - restart tracking (index returns to 0)
//   update    - present val/idx as the next candidate
//   val, idx  - candidate value (signed) and its index
//   max_idx   - index of the largest value seen since clear; ties keep
//               the earliest index because only strictly greater replaces
module nn_argmax_tracker
  import nn_host_pkg::*;
#(
  parameter int unsigned VAL_W = 16,
  parameter int unsigned IDX_W = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear,
  input  logic                    update,
  input  logic signed [VAL_W-1:0] val,
  input  logic        [IDX_W-1:0] idx,
  output logic        [IDX_W-1:0] max_idx
);

  logic signed [VAL_W-1:0] max_val;
  logic                    have;

  // First update after clear always takes; later ones need strictly greater.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      max_val <= '0;
      max_idx <= '0;
      have    <= 1'b0;
    end else if (clear) begin
      max_val <= '0;
      max_idx <= '0;
      have    <= 1'b0;
    end else if (update && (!have || (val > max_val))) begin
      max_val <= val;
      max_idx <= idx;
      have    <= 1'b1;
    end
  end

endmodule

// File: rtl/nn_bram_host_sequencer.sv
// Host-side initiator for the BRAM-based NN classifier.
// Loads N_X feature words into xij port A and N_WB weight/bias words into
// wb port A from a 64-bit valid/ready stream, pulses nn_start once the
// accelerator is ready, waits for nn_done (bounded by TIMEOUT), then reads
// N_OUT logits from xout port B one at a time and streams them out with
// the argmax class.
// Ports:
//   clk, rst                 - clock, asynchronous active-high reset
//   s_data/s_valid/s_ready   - load stream
//   m_data/m_valid/m_ready/m_last - logit stream
//   class_idx/class_valid    - argmax result, one-cycle pulse
//   busy, timeout_err        - status (timeout_err sticky until next load)
//   nn_ready/nn_start/nn_done - accelerator handshake
//   xij_*, wb_*              - registered BRAM port-A write ports
//   xout_enb/addrb/doutb     - xout BRAM port-B read port
module nn_bram_host_sequencer
  import nn_host_pkg::*;
#(
  parameter int unsigned DATA_W  = 64,
  parameter int unsigned ADDR_W  = 4,
  parameter int unsigned N_X     = DEF_N_X,
  parameter int unsigned N_WB    = DEF_N_WB,
  parameter int unsigned N_OUT   = DEF_N_OUT,
  parameter int unsigned OUT_W   = 16,
  parameter int unsigned RD_LAT  = 1,
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [DATA_W-1:0]          s_data,
  input  logic                       s_valid,
  output logic                       s_ready,
  output logic [OUT_W-1:0]           m_data,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic                       m_last,
  output logic [$clog2(N_OUT)-1:0]   class_idx,
  output logic                       class_valid,
  output logic                       busy,
  output logic                       timeout_err,
  input  logic                       nn_ready,
  output logic                       nn_start,
  input  logic                       nn_done,
  output logic                       xij_ena,
  output logic [WE_W-1:0]            xij_wea,
  output logic [ADDR_W-1:0]          xij_addra,
  output logic [DATA_W-1:0]          xij_dina,
  output logic                       wb_ena,
  output logic [WE_W-1:0]            wb_wea,
  output logic [ADDR_W-1:0]          wb_addra,
  output logic [DATA_W-1:0]          wb_dina,
  output logic                       xout_enb,
  output logic [ADDR_W-1:0]          xout_addrb,
  input  logic [OUT_W-1:0]           xout_doutb
);

  localparam int unsigned IDX_W = $clog2(N_OUT);
  localparam int unsigned WD_W  = $clog2(TIMEOUT + 1);
  localparam int unsigned RD_W  = $clog2(RD_LAT + 1);

  state_t            state, next_state;
  logic [ADDR_W-1:0] cnt;
  logic [IDX_W-1:0]  idx, idx_d;
  logic [WD_W-1:0]   wd_cnt;
  logic [RD_W-1:0]   rd_cnt;
  logic [IDX_W-1:0]  max_idx;

  logic accept, last_x, last_wb, last_out, wd_expire, rd_hit;
  logic wr_x, wr_wb, capture, m_hs, clear_max;

  assign accept    = s_valid & s_ready;
  assign last_x    = (cnt == ADDR_W'(N_X - 1));
  assign last_wb   = (cnt == ADDR_W'(N_WB - 1));
  assign last_out  = (idx == IDX_W'(N_OUT - 1));
  assign wd_expire = (wd_cnt == WD_W'(TIMEOUT - 1));
  assign rd_hit    = (rd_cnt == RD_W'(RD_LAT));

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Next-state logic. The first WAIT_RDY cycle covers the last wb write
  // landing, so nn_ready is only acted upon at the end of that cycle.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:      if (accept) next_state = LOAD_X;
      LOAD_X:    if (accept && last_x) next_state = LOAD_WB;
      LOAD_WB:   if (accept && last_wb) next_state = WAIT_RDY;
      WAIT_RDY:  if (nn_ready) next_state = START;
      START:     next_state = WAIT_DONE;
      WAIT_DONE: begin
        if (nn_done)        next_state = READ;
        else if (wd_expire) next_state = IDLE;
      end
      READ:      if (rd_hit) next_state = HOLD;
      HOLD:      if (m_ready) next_state = last_out ? DONE : READ;
      DONE:      next_state = IDLE;
      default:   next_state = IDLE;
    endcase
  end

  // Per-state datapath strobes
  always_comb begin
    wr_x      = 1'b0;
    wr_wb     = 1'b0;
    capture   = 1'b0;
    m_hs      = 1'b0;
    clear_max = 1'b0;
    idx_d     = idx;
    case (state)
      IDLE, LOAD_X: wr_x = accept;
      LOAD_WB:      wr_wb = accept;
      WAIT_DONE: begin
        if (nn_done) begin
          clear_max = 1'b1;
          idx_d     = '0;
        end
      end
      READ:         capture = rd_hit;
      HOLD: begin
        m_hs = m_ready;
        if (m_ready && !last_out) idx_d = idx + IDX_W'(1);
      end
      default: ;
    endcase
  end

  // Registered outputs and counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_ready     <= 1'b0;
      busy        <= 1'b0;
      nn_start    <= 1'b0;
      xout_enb    <= 1'b0;
      xout_addrb  <= '0;
      class_valid <= 1'b0;
      class_idx   <= '0;
      timeout_err <= 1'b0;
      m_data      <= '0;
      m_valid     <= 1'b0;
      m_last      <= 1'b0;
      xij_ena     <= 1'b0;
      xij_wea     <= '0;
      xij_addra   <= '0;
      xij_dina    <= '0;
      wb_ena      <= 1'b0;
      wb_wea      <= '0;
      wb_addra    <= '0;
      wb_dina     <= '0;
      cnt         <= '0;
      idx         <= '0;
      wd_cnt      <= '0;
      rd_cnt      <= '0;
    end else begin
      s_ready     <= is_load(next_state);
      busy        <= (next_state != IDLE);
      nn_start    <= (next_state == START);
      xout_enb    <= (next_state == READ);
      class_valid <= (next_state == DONE);
      if (next_state == READ) xout_addrb <= ADDR_W'(idx_d);
      if (next_state == DONE) class_idx  <= max_idx;
      idx <= idx_d;

      // Load index is 0 on entry to each load phase and wraps back to 0
      // after the last word of that phase.
      if (wr_x)  cnt <= last_x  ? '0 : cnt + ADDR_W'(1);
      if (wr_wb) cnt <= last_wb ? '0 : cnt + ADDR_W'(1);

      xij_ena <= wr_x;
      xij_wea <= wr_x ? WE_ALL : '0;
      if (wr_x) begin
        xij_addra <= cnt;
        xij_dina  <= s_data;
      end
      wb_ena <= wr_wb;
      wb_wea <= wr_wb ? WE_ALL : '0;
      if (wr_wb) begin
        wb_addra <= cnt;
        wb_dina  <= s_data;
      end

      wd_cnt <= (state == WAIT_DONE) ? wd_cnt + WD_W'(1) : '0;
      rd_cnt <= (state == READ && !rd_hit) ? rd_cnt + RD_W'(1) : '0;

      if (state == WAIT_DONE && !nn_done && wd_expire) timeout_err <= 1'b1;
      else if (state == IDLE && accept)                timeout_err <= 1'b0;

      if (capture) begin
        m_data  <= xout_doutb;
        m_valid <= 1'b1;
        m_last  <= last_out;
      end else if (m_hs) begin
        m_valid <= 1'b0;
        m_last  <= 1'b0;
      end
    end
  end

  nn_argmax_tracker #(
    .VAL_W (OUT_W),
    .IDX_W (IDX_W)
  ) u_argmax (
    .clk     (clk),
    .rst     (rst),
    .clear   (clear_max),
    .update  (capture),
    .val     (xout_doutb),
    .idx     (idx),
    .max_idx (max_idx)
  );

endmodule

// File: tb/tb_nn_bram_host_sequencer.sv
// Self-checking bench for nn_bram_host_sequencer: BRAM and accelerator
// models, a beat/class scoreboard, a vector table of inference scenarios
// and hand sequences for timeout and reset during HOLD.
module tb_nn_bram_host_sequencer;

  localparam int unsigned TIMEOUT  = 1023;
  localparam int unsigned DONE_DLY = 20;
  localparam int unsigned NW       = 19;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [63:0] s_data;
  logic        s_valid;
  logic        s_ready;
  logic [15:0] m_data;
  logic        m_valid;
  logic        m_ready;
  logic        m_last;
  logic [1:0]  class_idx;
  logic        class_valid;
  logic        busy;
  logic        timeout_err;
  logic        nn_ready;
  logic        nn_start;
  logic        nn_done;
  logic        xij_ena;
  logic [7:0]  xij_wea;
  logic [3:0]  xij_addra;
  logic [63:0] xij_dina;
  logic        wb_ena;
  logic [7:0]  wb_wea;
  logic [3:0]  wb_addra;
  logic [63:0] wb_dina;
  logic        xout_enb;
  logic [3:0]  xout_addrb;
  logic [15:0] xout_doutb = '0;

  always #5 clk = ~clk;

  nn_bram_host_sequencer #(.TIMEOUT(TIMEOUT)) dut (
    .clk         (clk),
    .rst         (rst),
    .s_data      (s_data),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .m_data      (m_data),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .m_last      (m_last),
    .class_idx   (class_idx),
    .class_valid (class_valid),
    .busy        (busy),
    .timeout_err (timeout_err),
    .nn_ready    (nn_ready),
    .nn_start    (nn_start),
    .nn_done     (nn_done),
    .xij_ena     (xij_ena),
    .xij_wea     (xij_wea),
    .xij_addra   (xij_addra),
    .xij_dina    (xij_dina),
    .wb_ena      (wb_ena),
    .wb_wea      (wb_wea),
    .wb_addra    (wb_addra),
    .wb_dina     (wb_dina),
    .xout_enb    (xout_enb),
    .xout_addrb  (xout_addrb),
    .xout_doutb  (xout_doutb)
  );

  typedef struct {
    logic [3:0][15:0] xo;
    int cls;
    int gap;
    int stall;
    int rdy_dly;
    int junk;
  } vec_t;

  typedef struct packed {
    logic [15:0] d;
    logic        l;
  } beat_t;

  beat_t       exp_q[$];
  int          cls_q[$];
  vec_t        vt[5];
  logic [63:0] words[NW];

  int  n_vec = 0;
  int  n_err = 0;
  int  start_hi = 0;
  int  cv_cnt = 0;
  int  mv_cnt = 0;
  int  stall = 0;
  int  stall_target = 0;
  time last_start_t = 0;
  bit  done_en = 1'b1;

  // BRAM models
  logic [63:0] xij_mem[16];
  logic [63:0] wb_mem[16];
  logic [15:0] xout_mem[16];
  int xij_wr = 0;
  int wb_wr = 0;
  int bad_we = 0;

  always @(posedge clk) begin
    if (xij_ena) begin
      xij_wr <= xij_wr + 1;
      if (xij_wea == 8'hFF) xij_mem[xij_addra] <= xij_dina;
      else bad_we <= bad_we + 1;
    end
    if (wb_ena) begin
      wb_wr <= wb_wr + 1;
      if (wb_wea == 8'hFF) wb_mem[wb_addra] <= wb_dina;
      else bad_we <= bad_we + 1;
    end
    if (xout_enb) xout_doutb <= xout_mem[xout_addrb];
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic out_any();
    return |{s_ready, m_data, m_valid, m_last, class_idx, class_valid, busy,
             timeout_err, nn_start, xij_ena, xij_wea, xij_addra, xij_dina,
             wb_ena, wb_wea, wb_addra, wb_dina, xout_enb, xout_addrb};
  endfunction

  function automatic vec_t mk(input logic [15:0] a, input logic [15:0] b,
                              input logic [15:0] c, input logic [15:0] d,
                              input int cls, input int gap, input int stl,
                              input int rdy, input int junk);
    vec_t v;
    v.xo[0] = a; v.xo[1] = b; v.xo[2] = c; v.xo[3] = d;
    v.cls = cls; v.gap = gap; v.stall = stl; v.rdy_dly = rdy; v.junk = junk;
    return v;
  endfunction

  // Accelerator model: done one cycle, DONE_DLY cycles after start
  initial begin
    nn_done = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst && nn_start && done_en) begin
        repeat (DONE_DLY - 1) @(negedge clk);
        nn_done = 1'b1;
        @(negedge clk);
        nn_done = 1'b0;
      end
    end
  end

  // Output monitor / scoreboard; also drives m_ready
  initial begin
    logic        prev_v;
    logic [15:0] prev_d;
    beat_t       e;
    int          ce;
    prev_v  = 1'b0;
    prev_d  = '0;
    m_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_v  = 1'b0;
        stall   = 0;
        m_ready = 1'b0;
      end else begin
        if (nn_start) begin
          start_hi++;
          last_start_t = $time;
        end
        if (class_valid) begin
          cv_cnt++;
          ce = (cls_q.size() > 0) ? cls_q.pop_front() : -1;
          check("class_idx", 64'(class_idx), 64'(ce));
        end
        if (m_valid) begin
          mv_cnt++;
          if (prev_v) check("m_data_stable", 64'(m_data), 64'(prev_d));
          if (stall >= stall_target) begin
            m_ready = 1'b1;
            if (exp_q.size() > 0) e = exp_q.pop_front();
            else begin e.d = ~m_data; e.l = ~m_last; end
            check("m_data", 64'(m_data), 64'(e.d));
            check("m_last", 64'(m_last), 64'(e.l));
            stall  = 0;
            prev_v = 1'b0;
          end else begin
            m_ready = 1'b0;
            stall++;
            prev_v = 1'b1;
            prev_d = m_data;
          end
        end else begin
          m_ready = 1'b0;
          prev_v  = 1'b0;
        end
      end
    end
  end

  task automatic gen_words();
    for (int i = 0; i < NW; i++) words[i] = {$urandom, $urandom};
    words[0]  = 64'h00BC0000_0282021F;
    words[18] = 64'hF1B3CBC6_FE00039D;
  endtask

  // Called at a negedge; returns at the negedge after the last handshake.
  task automatic do_load(input int gap);
    int t;
    for (int i = 0; i < NW; i++) begin
      s_data  = words[i];
      s_valid = 1'b1;
      t = 0;
      while (!s_ready && t < 200) begin
        @(negedge clk);
        t++;
      end
      if (t >= 200) check("s_ready_wait", 64'(t), 64'(0));
      @(negedge clk);
      if (gap != 0) begin
        s_valid = 1'b0;
        @(negedge clk);
      end
    end
    s_valid = 1'b0;
  endtask

  task automatic wait_class(input int c0);
    int t = 0;
    while (cv_cnt == c0 && t < 3000) begin
      @(negedge clk);
      t++;
    end
    check("class_wait_expired", 64'(t >= 3000), 64'(0));
  endtask

  task automatic run_vec(input vec_t v);
    int c0, s0, xw0, ww0;
    beat_t b;
    for (int k = 0; k < 4; k++) begin
      xout_mem[k] = v.xo[k];
      b.d = v.xo[k];
      b.l = (k == 3);
      exp_q.push_back(b);
    end
    cls_q.push_back(v.cls);
    stall_target = v.stall;
    gen_words();
    c0 = cv_cnt; s0 = start_hi; xw0 = xij_wr; ww0 = wb_wr;
    nn_ready = (v.rdy_dly == 0);
    do_load(v.gap);
    if (v.junk != 0) begin
      s_data  = 64'hDEADBEEF_CAFEF00D;
      s_valid = 1'b1;
      repeat (12) @(negedge clk);
      s_valid = 1'b0;
    end
    if (v.rdy_dly > 0) begin
      repeat (v.rdy_dly) @(negedge clk);
      check("start_gated", 64'(start_hi), 64'(s0));
      check("busy_gated", 64'(busy), 64'(1));
      nn_ready = 1'b1;
    end
    wait_class(c0);
    repeat (2) @(negedge clk);
    check("beats_left", 64'(exp_q.size()), 64'(0));
    check("class_left", 64'(cls_q.size()), 64'(0));
    check("start_pulses", 64'(start_hi - s0), 64'(1));
    check("xij_writes", 64'(xij_wr - xw0), 64'(9));
    check("wb_writes", 64'(wb_wr - ww0), 64'(10));
    for (int i = 0; i < 9; i++) check("xij_mem", xij_mem[i], words[i]);
    for (int i = 0; i < 10; i++) check("wb_mem", wb_mem[i], words[9+i]);
    check("busy_idle", 64'(busy), 64'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int  t, m0, c0;
    s_valid  = 1'b0;
    s_data   = '0;
    nn_ready = 1'b1;
    for (int i = 0; i < 16; i++) xout_mem[i] = '0;

    //          x0       x1       x2       x3      cls gap stall rdy junk
    vt[0] = mk(16'h0010, 16'hFFF0, 16'h0123, 16'h0040, 2, 0, 0, 0, 0);
    vt[1] = mk(16'h1234, 16'h0001, 16'h8001, 16'h1235, 3, 1, 5, 0, 1);
    vt[2] = mk(16'h8000, 16'h7FFF, 16'h7FFF, 16'h0000, 1, 0, 0, 0, 0);
    vt[3] = mk(16'hFFF0, 16'hFFFC, 16'h8000, 16'hFFFA, 1, 0, 1, 10, 0);
    vt[4] = mk(16'h0005, 16'h0005, 16'h0005, 16'h0005, 0, 0, 2, 0, 0);

    #1 rst = 1'b1;
    #2 check("reset_outputs", 64'(out_any()), 64'(0));
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_reset", 64'(s_ready), 64'(1));
    check("busy_after_reset", 64'(busy), 64'(0));

    for (int i = 0; i < 5; i++) run_vec(vt[i]);
    check("bad_byte_enables", 64'(bad_we), 64'(0));

    // Timeout: accelerator never finishes
    done_en = 1'b0;
    gen_words();
    m0 = mv_cnt;
    c0 = cv_cnt;
    do_load(0);
    t = 0;
    while (!timeout_err && t < 1500) begin
      @(negedge clk);
      t++;
    end
    check("timeout_seen", 64'(timeout_err), 64'(1));
    check("timeout_cycle", 64'(($time - last_start_t) / 10), 64'(TIMEOUT + 1));
    check("timeout_idle", 64'(busy), 64'(0));
    check("timeout_ready", 64'(s_ready), 64'(1));
    check("timeout_no_beats", 64'(mv_cnt - m0), 64'(0));
    check("timeout_no_class", 64'(cv_cnt - c0), 64'(0));
    s_data  = words[0];
    s_valid = 1'b1;
    @(negedge clk);
    s_valid = 1'b0;
    check("timeout_cleared", 64'(timeout_err), 64'(0));
    check("busy_after_word", 64'(busy), 64'(1));
    done_en = 1'b1;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset while a beat is held
    stall_target = 1000000;
    for (int k = 0; k < 4; k++) xout_mem[k] = 16'h1111 * 16'(k + 1);
    gen_words();
    do_load(0);
    t = 0;
    while (!m_valid && t < 500) begin
      @(negedge clk);
      t++;
    end
    check("hold_reached", 64'(m_valid), 64'(1));
    repeat (2) @(negedge clk);
    check("hold_held", 64'(m_valid), 64'(1));
    #2 rst = 1'b1;
    #1 check("async_reset_outputs", 64'(out_any()), 64'(0));
    repeat (2) @(negedge clk);
    rst = 1'b0;
    stall_target = 0;
    @(negedge clk);
    run_vec(vt[0]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
